multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: a Moore FSM that walks each instruction
// through fetch, decode, execute, memory and write-back steps.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               1 = begin or keep fetching instructions
//   opcode[5:0]       instruction opcode, sampled in DECODE
//   SelectIns         IorD memory address select (0 = PC, 1 = ALU output)
//   RegWrite, RegDst, MemWrite, MemtoReg, BEQ, ALUSrcA   datapath controls
//   ALUSrcB[1:0]      00 = B, 01 = constant 1, 10 = IMM32
//   PCSrc[1:0]        00 = PC+1, 01 = branch target, 10 = jump address
//   pc_write, ir_write  PC update enable, instruction latch enable
//   state[3:0]        current FSM state code
//   instr_count[15:0] retired-instruction counter (wraps)
//   halted, illegal   HALT reached, sticky illegal-opcode flag
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  opcode,
  output logic        SelectIns,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        BEQ,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic        pc_write,
  output logic        ir_write,
  output logic [3:0]  state,
  output logic [15:0] instr_count,
  output logic        halted,
  output logic        illegal
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_SKIP     = 4'd12,
    S_HALT     = 4'd13
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [OP_W-1:0]   opcode_q;
  logic [CNT_W-1:0]  count_q;
  logic              illegal_q;
  logic              unused_opcode_bits;

  // Opcode class dispatch out of DECODE; anything unlisted is skipped.
  function automatic state_e dispatch(input logic [OP_W-1:0] op);
    state_e s;
    casez (op)
      6'b00????:        s = S_EXEC_R;
      6'b01????:        s = S_EXEC_I;
      6'b100000,
      6'b100001:        s = S_BRANCH;
      6'b110000:        s = S_JUMP;
      6'b111000,
      6'b111001:        s = S_MEM_ADDR;
      6'b111111:        s = S_HALT;
      default:          s = S_SKIP;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and Moore control decode
  always_comb begin
    state_d   = state_q;
    SelectIns = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    BEQ       = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        state_d = dispatch(opcode);
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        // Keep the ALU operands of whichever EXEC state led here.
        ALUSrcA  = 1'b1;
        ALUSrcB  = (opcode_q[5:4] == 2'b01) ? 2'b10 : 2'b00;
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        pc_write = 1'b1;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = opcode_q[0] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        pc_write = 1'b1;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_MEM_WR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        MemWrite = 1'b1;
        pc_write = 1'b1;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_BRANCH: begin
        // BEQ opcode ends in 0, BNE in 1.
        ALUSrcA  = 1'b1;
        BEQ      = ~opcode_q[0];
        PCSrc    = 2'b01;
        pc_write = 1'b1;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_SKIP: begin
        pc_write = 1'b1;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Opcode latch, written on the DECODE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   opcode_q <= '0;
    else if (state_q == S_DECODE) opcode_q <= opcode;
  end

  // Retire counter: every pc_write state retires exactly one instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_q <= '0;
    else if (pc_write) count_q <= count_q + CNT_W'(1);
  end

  // Sticky illegal flag, set on the DECODE-to-SKIP edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          illegal_q <= 1'b0;
    else if (state_q == S_DECODE && state_d == S_SKIP)   illegal_q <= 1'b1;
  end

  assign state              = 4'(state_q);
  assign instr_count        = count_q;
  assign illegal            = illegal_q;
  assign unused_opcode_bits = ^opcode_q[3:1];

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class,
// checks per-cycle state and controls, sticky illegal, halt, async reset,
// run-drop completion and counter wrap.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [5:0]  opcode;
  logic        SelectIns, RegWrite, RegDst, MemWrite, MemtoReg, BEQ, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc;
  logic        pc_write, ir_write;
  logic [3:0]  state;
  logic [15:0] instr_count;
  logic        halted, illegal;
  logic [13:0] ctl_now;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .SelectIns(SelectIns), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .BEQ(BEQ), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .pc_write(pc_write), .ir_write(ir_write),
    .state(state), .instr_count(instr_count), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl_now = {SelectIns, RegWrite, RegDst, MemWrite, MemtoReg, BEQ,
                    ALUSrcA, ALUSrcB, PCSrc, pc_write, ir_write, halted};

  // Expected control word; argument order matches ctl_now minus SelectIns.
  function automatic logic [13:0] ctl(input logic rw, rd, mw, m2r, beq, asa,
                                      input logic [1:0] asb, pcs,
                                      input logic pcw, irw, hlt);
    return {1'b0, rw, rd, mw, m2r, beq, asa, asb, pcs, pcw, irw, hlt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [13:0] c);
    check({tag, "/state"}, 32'(state), 32'(st));
    check({tag, "/ctl"}, 32'(ctl_now), 32'(c));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [13:0] c_idle, c_fetch, c_dec, c_exr, c_exi, c_wbr, c_wbi, c_madr,
               c_mrd, c_wbm, c_mwr, c_beq, c_bne, c_jmp, c_skip, c_halt;

  initial begin
    c_idle = '0;
    c_dec  = '0;
    //           rw   rd   mw   m2r  beq  asa  asb    pcs    pcw  irw  hlt
    c_fetch = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b1,1'b0);
    c_exr   = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0);
    c_exi   = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0);
    c_wbr   = ctl(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b1,1'b0,1'b0);
    c_wbi   = ctl(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b1,1'b0,1'b0);
    c_madr  = c_exi;
    c_mrd   = c_exi;
    c_wbm   = ctl(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0);
    c_mwr   = ctl(1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,1'b1,1'b0,1'b0);
    c_beq   = ctl(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b01,1'b1,1'b0,1'b0);
    c_bne   = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b1,1'b0,1'b0);
    c_jmp   = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,1'b0,1'b0);
    c_skip  = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0);
    c_halt  = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1);

    // Reset and idle with run low
    rst_n = 1'b0; run = 1'b0; opcode = 6'b000000;
    #12;
    check("rst/count", 32'(instr_count), 32'h0);
    check("rst/illegal", 32'(illegal), 32'h0);
    expect_cycle("rst", 4'd0, c_idle);
    rst_n = 1'b1;
    step(); step();
    expect_cycle("idle_hold", 4'd0, c_idle);

    // R-type: 1,2,3,5,1
    opcode = 6'b000010; run = 1'b1;
    step(); expect_cycle("r/fetch", 4'd1, c_fetch);
    step(); expect_cycle("r/decode", 4'd2, c_dec);
    step(); expect_cycle("r/exec", 4'd3, c_exr);
    step(); expect_cycle("r/wb", 4'd5, c_wbr);
    check("r/count_pre", 32'(instr_count), 32'd0);
    step(); expect_cycle("r/next", 4'd1, c_fetch);
    check("r/count", 32'(instr_count), 32'd1);

    // I-type: 2,4,5,1
    opcode = 6'b010101;
    step(); expect_cycle("i/decode", 4'd2, c_dec);
    step(); expect_cycle("i/exec", 4'd4, c_exi);
    step(); expect_cycle("i/wb", 4'd5, c_wbi);
    step(); expect_cycle("i/next", 4'd1, c_fetch);
    check("i/count", 32'(instr_count), 32'd2);

    // LW: 2,6,7,8,1
    opcode = 6'b111000;
    step(); expect_cycle("lw/decode", 4'd2, c_dec);
    step(); expect_cycle("lw/addr", 4'd6, c_madr);
    step(); expect_cycle("lw/rd", 4'd7, c_mrd);
    step(); expect_cycle("lw/wb", 4'd8, c_wbm);
    step(); expect_cycle("lw/next", 4'd1, c_fetch);
    check("lw/count", 32'(instr_count), 32'd3);

    // SW: 2,6,9,1 with MemWrite for one cycle only
    opcode = 6'b111001;
    step(); expect_cycle("sw/decode", 4'd2, c_dec);
    step(); expect_cycle("sw/addr", 4'd6, c_madr);
    step(); expect_cycle("sw/wr", 4'd9, c_mwr);
    step(); expect_cycle("sw/next", 4'd1, c_fetch);
    check("sw/memwrite_off", 32'(MemWrite), 32'd0);
    check("sw/count", 32'(instr_count), 32'd4);

    // BEQ, BNE, J: three cycles each
    opcode = 6'b100000;
    step(); expect_cycle("beq/decode", 4'd2, c_dec);
    step(); expect_cycle("beq/br", 4'd10, c_beq);
    step(); expect_cycle("beq/next", 4'd1, c_fetch);
    opcode = 6'b100001;
    step(); expect_cycle("bne/decode", 4'd2, c_dec);
    step(); expect_cycle("bne/br", 4'd10, c_bne);
    step(); expect_cycle("bne/next", 4'd1, c_fetch);
    opcode = 6'b110000;
    step(); expect_cycle("j/decode", 4'd2, c_dec);
    step(); expect_cycle("j/jump", 4'd11, c_jmp);
    step(); expect_cycle("j/next", 4'd1, c_fetch);
    check("j/count", 32'(instr_count), 32'd7);

    // Illegal opcode goes through SKIP and sets sticky flag
    opcode = 6'b101010;
    step(); expect_cycle("ill/decode", 4'd2, c_dec);
    check("ill/flag_pre", 32'(illegal), 32'd0);
    step(); expect_cycle("ill/skip", 4'd12, c_skip);
    check("ill/flag", 32'(illegal), 32'd1);
    step(); expect_cycle("ill/next", 4'd1, c_fetch);
    check("ill/count", 32'(instr_count), 32'd8);

    // R-type with run dropped in EXEC_R: completes then idles
    opcode = 6'b000010;
    step(); expect_cycle("drop/decode", 4'd2, c_dec);
    step(); expect_cycle("drop/exec", 4'd3, c_exr);
    run = 1'b0;
    step(); expect_cycle("drop/wb", 4'd5, c_wbr);
    step(); expect_cycle("drop/idle", 4'd0, c_idle);
    check("drop/count", 32'(instr_count), 32'd9);
    check("drop/illegal_sticky", 32'(illegal), 32'd1);
    step(); expect_cycle("drop/idle2", 4'd0, c_idle);

    // Counter wrap: preload the retire counter to 0xFFFF while idle
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    #1;
    check("wrap/preload", 32'(instr_count), 32'hFFFF);
    opcode = 6'b110000; run = 1'b1;
    step(); expect_cycle("wrap/fetch", 4'd1, c_fetch);
    step(); step(); expect_cycle("wrap/jump", 4'd11, c_jmp);
    step(); check("wrap/count", 32'(instr_count), 32'h0000);

    // Asynchronous reset during MEM_WR
    opcode = 6'b111001;
    step(); step(); step(); expect_cycle("rstwr/wr", 4'd9, c_mwr);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr/memwrite", 32'(MemWrite), 32'd0);
    check("rstwr/regwrite", 32'(RegWrite), 32'd0);
    check("rstwr/state", 32'(state), 32'd0);
    check("rstwr/count", 32'(instr_count), 32'd0);
    check("rstwr/illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;

    // HALT is terminal even with run held high
    opcode = 6'b111111;
    step(); expect_cycle("halt/fetch", 4'd1, c_fetch);
    step(); expect_cycle("halt/decode", 4'd2, c_dec);
    step(); expect_cycle("halt/halt", 4'd13, c_halt);
    check("halt/count", 32'(instr_count), 32'd0);
    opcode = 6'b000010;
    step(); step(); step();
    expect_cycle("halt/stay", 4'd13, c_halt);
    check("halt/count_stay", 32'(instr_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
